clk_period_meter: RTL and testbench

- Measures a slow, free-running square wave such as a divided "slow clock" against the system clock.
- Reports period, high time and the equivalent toggle divisor m_est, where m_est = period/2 for a 50 % clock.
- Used for self-check of clock-divider outputs and for measuring external slow signals.
- Sits beside the clock dividers; purely synchronous to the system clock.

---
 rtl/clk_period_meter.sv | 195 +++++++++++++++++++
 tb/tb_clk_period_meter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow square wave
// (e.g. a divided clock) in system-clock cycles, and derives the equivalent
// toggle divisor m_est = period >> 1.
//
// Optional build macro: CLK_PERIOD_METER_AVG_EN
//   When defined, reported period/high_time are the mean of the last four
//   measurements and valid only fires once four consecutive measurements
//   have been collected since lock.
module clk_period_meter #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] m_est,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        COUNT      = 2'd1,
        STALE      = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] hi_cnt_reg;

    logic sync1_reg;
    logic sig_s;
    logic sig_d;
    logic rise;
    logic fall;

    // Two-flop synchronizer followed by one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sig_s     <= 1'b0;
            sig_d     <= 1'b0;
        end else begin
            sync1_reg <= sig_in;
            sig_s     <= sync1_reg;
            sig_d     <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_d;
    assign fall = ~sig_s & sig_d;

`ifdef CLK_PERIOD_METER_AVG_EN
    localparam int SUM_W = CNT_W + 2;

    logic [CNT_W-1:0] hist_p [4];
    logic [CNT_W-1:0] hist_h [4];
    logic [SUM_W-1:0] sum_p_reg;
    logic [SUM_W-1:0] sum_h_reg;
    logic [SUM_W-1:0] sum_p_next;
    logic [SUM_W-1:0] sum_h_next;
    logic [1:0]       idx_reg;
    logic [2:0]       fill_reg;
    logic             meas;
    logic             hist_full;

    assign meas      = (state_reg == COUNT) && rise;
    assign hist_full = (fill_reg == 3'd4);

    // Running sums: add the new sample, drop the one it overwrites once full.
    always_comb begin
        sum_p_next = sum_p_reg + SUM_W'(cnt_reg);
        sum_h_next = sum_h_reg + SUM_W'(hi_cnt_reg);
        if (hist_full) begin
            sum_p_next = sum_p_next - SUM_W'(hist_p[idx_reg]);
            sum_h_next = sum_h_next - SUM_W'(hist_h[idx_reg]);
        end
    end

    // History ring; entries are only read once fill_reg says they are live.
    always_ff @(posedge clk) begin
        if (meas) begin
            hist_p[idx_reg] <= cnt_reg;
            hist_h[idx_reg] <= hi_cnt_reg;
        end
    end
`endif

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= WAIT_FIRST;
            cnt_reg    <= '0;
            hi_cnt_reg <= '0;
            period     <= '0;
            high_time  <= '0;
            m_est      <= '0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
            sum_p_reg  <= '0;
            sum_h_reg  <= '0;
            idx_reg    <= '0;
            fill_reg   <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state_reg)
                // No reference edge yet; cnt only serves as a stale watchdog.
                WAIT_FIRST: begin
                    if (rise) begin
                        state_reg  <= COUNT;
                        cnt_reg    <= ONE_C;
                        hi_cnt_reg <= '0;
                    end else if (cnt_reg == TIMEOUT_C - ONE_C) begin
                        state_reg <= STALE;
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + ONE_C;
                    end
                end

                // A rise closes the interval; it wins over the timeout check
                // on the cycle cnt reaches TIMEOUT.
                COUNT: begin
                    if (rise) begin
`ifdef CLK_PERIOD_METER_AVG_EN
                        sum_p_reg <= sum_p_next;
                        sum_h_reg <= sum_h_next;
                        idx_reg   <= idx_reg + 2'd1;
                        if (!hist_full) begin
                            fill_reg <= fill_reg + 3'd1;
                        end
                        if (fill_reg >= 3'd3) begin
                            period    <= sum_p_next[SUM_W-1:2];
                            high_time <= sum_h_next[SUM_W-1:2];
                            m_est     <= sum_p_next[SUM_W-1:3];
                            valid     <= 1'b1;
                            locked    <= 1'b1;
                        end
`else
                        period    <= cnt_reg;
                        high_time <= hi_cnt_reg;
                        m_est     <= cnt_reg >> 1;
                        valid     <= 1'b1;
                        locked    <= 1'b1;
`endif
                        cnt_reg    <= ONE_C;
                        hi_cnt_reg <= '0;
                    end else if (cnt_reg == TIMEOUT_C) begin
                        state_reg <= STALE;
                        timeout   <= 1'b1;
                        locked    <= 1'b0;
`ifdef CLK_PERIOD_METER_AVG_EN
                        sum_p_reg <= '0;
                        sum_h_reg <= '0;
                        idx_reg   <= '0;
                        fill_reg  <= '0;
`endif
                    end else begin
                        cnt_reg <= cnt_reg + ONE_C;
                        if (fall) begin
                            hi_cnt_reg <= cnt_reg;
                        end
                    end
                end

                // Hold last results; the interval ending at the next rise is
                // unusable, so that rise only restarts counting.
                STALE: begin
                    if (rise) begin
                        state_reg  <= COUNT;
                        cnt_reg    <= ONE_C;
                        hi_cnt_reg <= '0;
                        timeout    <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= WAIT_FIRST;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with TIMEOUT=64 (default build).
module tb_clk_period_meter;

    localparam int CNT_W = 32;
    localparam int TO    = 64;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] m_est;
    logic             valid;
    logic             locked;
    logic             timeout;

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .m_est     (m_est),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    // Observer: counts valid pulses and notes when timeout first rises.
    int valid_cnt = 0;
    int last_vcyc = -1;
    int prev_vcyc = -1;
    int to_cyc    = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            valid_cnt = 0;
            last_vcyc = -1;
            prev_vcyc = -1;
            to_cyc    = -1;
        end else begin
            if (valid) begin
                prev_vcyc = last_vcyc;
                last_vcyc = cyc;
                valid_cnt++;
            end
            if (timeout && to_cyc < 0) to_cyc = cyc;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            wait_cyc(h);
            sig_in = 1'b0;
            wait_cyc(l);
        end
    endtask

    typedef struct {
        int h;
        int l;
        int exp_p;
        int exp_h;
        int exp_m;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{5,  5,  10, 5,  5};
        vecs[1] = '{3,  7,  10, 3,  5};
        vecs[2] = '{5,  6,  11, 5,  5};
        vecs[3] = '{1,  9,  10, 1,  5};
        vecs[4] = '{7,  3,  10, 7,  5};
        vecs[5] = '{32, 31, 63, 32, 31};
        vecs[6] = '{32, 32, 64, 32, 32};

        // Reset state, asserted asynchronously between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_m", m_est, 0);
        chk("rst_valid", valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_timeout", timeout, 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);

        // Steady waves: five rises give four measurements.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            wave(vecs[v].h, vecs[v].l, 4);
            sig_in = 1'b1;
            wait_cyc(4);
            sig_in = 1'b0;
            wait_cyc(1);
            $display("vec %0d: h=%0d l=%0d -> period=%0d high=%0d m=%0d valids=%0d",
                     v, vecs[v].h, vecs[v].l, period, high_time, m_est, valid_cnt);
            chk($sformatf("v%0d_valid_cnt", v), valid_cnt, 4);
            chk($sformatf("v%0d_period", v), period, vecs[v].exp_p);
            chk($sformatf("v%0d_high", v), high_time, vecs[v].exp_h);
            chk($sformatf("v%0d_m", v), m_est, vecs[v].exp_m);
            chk($sformatf("v%0d_gap", v), last_vcyc - prev_vcyc, vecs[v].exp_p);
            chk($sformatf("v%0d_locked", v), locked, 1);
            chk($sformatf("v%0d_timeout", v), timeout, 0);
        end

        // Lock at period 10, then hold low until stale.
        begin
            int base;
            do_reset();
            wave(5, 5, 2);
            sig_in = 1'b1;
            wait_cyc(5);
            sig_in = 1'b0;
            for (int i = 0; i < 200 && to_cyc < 0; i++) wait_cyc(1);
            $display("stale: last valid cyc %0d, timeout cyc %0d", last_vcyc, to_cyc);
            chk("stale_delay", to_cyc - last_vcyc, TO);
            chk("stale_timeout", timeout, 1);
            chk("stale_locked", locked, 0);
            chk("stale_period", period, 10);
            chk("stale_high", high_time, 5);
            chk("stale_m", m_est, 5);
            base = valid_cnt;
            wave(5, 5, 1);
            chk("stale_rise1_novalid", valid_cnt, base);
            chk("stale_rise1_timeout", timeout, 0);
            sig_in = 1'b1;
            wait_cyc(5);
            sig_in = 1'b0;
            wait_cyc(2);
            $display("stale recovery: period=%0d valids=%0d", period, valid_cnt - base);
            chk("stale_rise2_valid", valid_cnt, base + 1);
            chk("stale_rise2_period", period, 10);
            chk("stale_rise2_locked", locked, 1);
        end

        // Interval of 65 cycles must go stale and its closing rise gives no valid.
        do_reset();
        wave(5, 5, 1);
        sig_in = 1'b1;
        wait_cyc(5);
        sig_in = 1'b0;
        wait_cyc(60);
        sig_in = 1'b1;
        wait_cyc(6);
        $display("interval65: valids=%0d timeout cyc offset=%0d", valid_cnt, to_cyc - last_vcyc);
        chk("i65_stale_seen", to_cyc - last_vcyc, TO);
        chk("i65_valid_cnt", valid_cnt, 1);
        chk("i65_period", period, 10);
        chk("i65_timeout_cleared", timeout, 0);

        // Reset asserted mid-period after lock.
        do_reset();
        wave(5, 5, 2);
        sig_in = 1'b1;
        wait_cyc(3);
        chk("mid_locked_before", locked, 1);
        #2 rst_n = 1'b0;
        #1;
        $display("mid reset: period=%0d locked=%0d", period, locked);
        chk("mid_period", period, 0);
        chk("mid_high", high_time, 0);
        chk("mid_m", m_est, 0);
        chk("mid_locked", locked, 0);
        chk("mid_valid", valid, 0);
        chk("mid_timeout", timeout, 0);
        sig_in = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
        wave(5, 5, 1);
        chk("mid_rise1_novalid", valid_cnt, 0);
        sig_in = 1'b1;
        wait_cyc(4);
        $display("mid recovery: period=%0d high=%0d valids=%0d", period, high_time, valid_cnt);
        chk("mid_rise2_valid", valid_cnt, 1);
        chk("mid_rise2_period", period, 10);
        chk("mid_rise2_high", high_time, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
